// File: rtl/dla_pe_result_drain_pkg.sv
// Shared configuration, types and widths for the PE result drain stage.
// The block is configured here; the FIFO and the top both derive their
// widths from these values so the two can never disagree.
package dla_pe_result_drain_pkg;

    localparam int NUM_RESULTS_PER_CYCLE = 4;   // results per PE valid cycle
    localparam int NUM_FEATURES          = 4;   // features per result
    localparam int RESULT_WIDTH          = 32;  // bits per feature result
    localparam int FIFO_DEPTH            = 8;   // result words buffered (power of two, >= 2)

    localparam int BEAT_W = NUM_FEATURES * RESULT_WIDTH;
    localparam int WORD_W = NUM_RESULTS_PER_CYCLE * BEAT_W;
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;                 // address plus wrap bit
    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W  = (NUM_RESULTS_PER_CYCLE > 1) ? $clog2(NUM_RESULTS_PER_CYCLE) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_RESULTS_PER_CYCLE - 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FIFO_DEPTH);

    // One output beat; element 0 of a word sits in the least significant bits.
    typedef logic [BEAT_W-1:0] result_beat_t;
    typedef result_beat_t [NUM_RESULTS_PER_CYCLE-1:0] result_word_t;

    // Serializer state: EMPTY has no head word, STREAM presents one.
    typedef enum logic {
        SER_EMPTY  = 1'b0,
        SER_STREAM = 1'b1
    } ser_state_e;

endpackage

// File: rtl/dla_pe_result_fifo.sv
// Result word FIFO: flop storage with wrap-bit pointers. The head word is
// read straight from the storage flops so the serializer sees it the cycle
// after it is written (first-word-fall-through).
module dla_pe_result_fifo
    import dla_pe_result_drain_pkg::*;
(
    input  logic               clk,
    input  logic               i_sclrn,
    input  logic               i_wr_en,
    input  result_word_t       i_wr_data,
    input  logic               i_rd_en,
    output result_word_t       o_rd_data,
    output logic               o_full,
    output logic               o_empty,
    output logic [PTR_W-1:0]   o_count
);

    result_word_t     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    // Pointer advance; the caller only asserts write/read when legal.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (i_rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Pointer registers, cleared by reset so buffered words are discarded.
    always_ff @(posedge clk) begin
        if (!i_sclrn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: empty slots are never presented downstream.
    always_ff @(posedge clk) begin
        if (i_wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= i_wr_data;
    end

    assign o_rd_data = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign o_empty   = (wr_ptr_q == rd_ptr_q);
    assign o_full    = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                       (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign o_count   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/dla_pe_result_drain.sv
// PE result drain: buffers un-stallable result words, serializes each into
// NUM_RESULTS_PER_CYCLE beats on a valid/ready stream, and tracks the
// credits that let the sequencer issue flushes without overflowing us.
//
// Output handshake: a beat transfers on a clock edge where o_out_valid and
// i_out_ready are both 1. While o_out_valid is 1 and i_out_ready is 0,
// o_out_valid, o_out_data and o_out_last stay unchanged. o_out_valid is a
// state flop and never depends combinationally on i_out_ready.
module dla_pe_result_drain
    import dla_pe_result_drain_pkg::*;
(
    input  logic                clk,
    input  logic                i_sclrn,
    input  logic                i_res_valid,
    input  logic [WORD_W-1:0]   i_res_data,
    input  logic                i_credit_take,
    output logic                o_credit_avail,
    output logic [CRED_W-1:0]   o_credits,
    output logic                o_out_valid,
    output logic [BEAT_W-1:0]   o_out_data,
    output logic                o_out_last,
    input  logic                i_out_ready,
    output logic                o_error
);

    result_word_t      head_word;
    logic              fifo_full, fifo_empty;
    logic [PTR_W-1:0]  fifo_count, count_next;

    ser_state_e        state_q, state_d;
    logic [IDX_W-1:0]  beat_idx_q, beat_idx_d;
    logic              out_last_q, out_last_d;
    logic [CRED_W-1:0] credits_q, credits_d;
    logic              credit_avail_q, credit_avail_d;
    logic              error_q, error_d;

    logic xfer, pop, wr_accept, overflow, take_err, ret_err;

    dla_pe_result_fifo u_fifo (
        .clk       (clk),
        .i_sclrn   (i_sclrn),
        .i_wr_en   (wr_accept),
        .i_wr_data (result_word_t'(i_res_data)),
        .i_rd_en   (pop),
        .o_rd_data (head_word),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_count   (fifo_count)
    );

    // Serializer next state: beat index, head pop, and EMPTY/STREAM decision
    // based on the occupancy the FIFO will have after this edge.
    always_comb begin
        xfer       = (state_q == SER_STREAM) && i_out_ready;
        pop        = xfer && (beat_idx_q == LAST_IDX) && !fifo_empty;
        // A full FIFO still takes a word when the head leaves in the same cycle.
        wr_accept  = i_res_valid && (!fifo_full || pop);
        overflow   = i_res_valid && fifo_full && !pop;
        count_next = fifo_count + PTR_W'(wr_accept) - PTR_W'(pop);

        beat_idx_d = beat_idx_q;
        if (pop)       beat_idx_d = '0;
        else if (xfer) beat_idx_d = beat_idx_q + IDX_W'(1);

        state_d = state_q;
        case (state_q)
            SER_EMPTY:  if (count_next != '0) state_d = SER_STREAM;
            SER_STREAM: if (count_next == '0) state_d = SER_EMPTY;
            default:    state_d = SER_EMPTY;
        endcase

        out_last_d = (state_d == SER_STREAM) && (beat_idx_d == LAST_IDX);
    end

    // Credit counter: a take and a return in the same cycle cancel; an
    // impossible take or return leaves the count alone and flags an error.
    always_comb begin
        credits_d = credits_q;
        take_err  = 1'b0;
        ret_err   = 1'b0;
        case ({i_credit_take, pop})
            2'b10: begin
                if (credits_q == '0) take_err  = 1'b1;
                else                 credits_d = credits_q - CRED_W'(1);
            end
            2'b01: begin
                if (credits_q == CRED_MAX) ret_err   = 1'b1;
                else                       credits_d = credits_q + CRED_W'(1);
            end
            default: ;
        endcase
        credit_avail_d = (credits_d != '0);
        error_d        = error_q | overflow | take_err | ret_err;
    end

    // Serializer, credit and sticky error registers.
    always_ff @(posedge clk) begin
        if (!i_sclrn) begin
            state_q        <= SER_EMPTY;
            beat_idx_q     <= '0;
            out_last_q     <= 1'b0;
            credits_q      <= CRED_MAX;
            credit_avail_q <= 1'b1;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_idx_q     <= beat_idx_d;
            out_last_q     <= out_last_d;
            credits_q      <= credits_d;
            credit_avail_q <= credit_avail_d;
            error_q        <= error_d;
        end
    end

    // Stale storage is masked so the idle stream shows zero data.
    assign o_out_valid    = (state_q == SER_STREAM);
    assign o_out_data     = o_out_valid ? head_word[beat_idx_q] : '0;
    assign o_out_last     = out_last_q;
    assign o_credits      = credits_q;
    assign o_credit_avail = credit_avail_q;
    assign o_error        = error_q;

endmodule
